// File: rtl/br_amba_axil_arbiter_2to1.sv
// br_amba_axil_arbiter_2to1
// Merges two AXI4-Lite requesters onto one shared AXI4-Lite initiator port.
// Writes and reads are arbitrated independently, and each path has its own
// round-robin pointer. At most one write and one read can be outstanding on
// the shared port. No payload is stored here: address, data and user fields
// are muxed straight from the granted requester.
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   in0_* / in1_*       : requester-side AW, W, B, AR and R channels
//   out_*               : shared initiator-side AW, W, B, AR and R channels
module br_amba_axil_arbiter_2to1 #(
  parameter int AddrWidth   = 40,
  parameter int DataWidth   = 64,
  parameter int AWUserWidth = 1,
  parameter int WUserWidth  = 1,
  parameter int ARUserWidth = 1,
  parameter int RUserWidth  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // requester 0
  input  logic [AddrWidth-1:0]   in0_awaddr,
  input  logic [2:0]             in0_awprot,
  input  logic [AWUserWidth-1:0] in0_awuser,
  input  logic                   in0_awvalid,
  output logic                   in0_awready,
  input  logic [DataWidth-1:0]   in0_wdata,
  input  logic [DataWidth/8-1:0] in0_wstrb,
  input  logic [WUserWidth-1:0]  in0_wuser,
  input  logic                   in0_wvalid,
  output logic                   in0_wready,
  output logic [1:0]             in0_bresp,
  output logic                   in0_bvalid,
  input  logic                   in0_bready,
  input  logic [AddrWidth-1:0]   in0_araddr,
  input  logic [2:0]             in0_arprot,
  input  logic [ARUserWidth-1:0] in0_aruser,
  input  logic                   in0_arvalid,
  output logic                   in0_arready,
  output logic [DataWidth-1:0]   in0_rdata,
  output logic [1:0]             in0_rresp,
  output logic [RUserWidth-1:0]  in0_ruser,
  output logic                   in0_rvalid,
  input  logic                   in0_rready,
  // requester 1
  input  logic [AddrWidth-1:0]   in1_awaddr,
  input  logic [2:0]             in1_awprot,
  input  logic [AWUserWidth-1:0] in1_awuser,
  input  logic                   in1_awvalid,
  output logic                   in1_awready,
  input  logic [DataWidth-1:0]   in1_wdata,
  input  logic [DataWidth/8-1:0] in1_wstrb,
  input  logic [WUserWidth-1:0]  in1_wuser,
  input  logic                   in1_wvalid,
  output logic                   in1_wready,
  output logic [1:0]             in1_bresp,
  output logic                   in1_bvalid,
  input  logic                   in1_bready,
  input  logic [AddrWidth-1:0]   in1_araddr,
  input  logic [2:0]             in1_arprot,
  input  logic [ARUserWidth-1:0] in1_aruser,
  input  logic                   in1_arvalid,
  output logic                   in1_arready,
  output logic [DataWidth-1:0]   in1_rdata,
  output logic [1:0]             in1_rresp,
  output logic [RUserWidth-1:0]  in1_ruser,
  output logic                   in1_rvalid,
  input  logic                   in1_rready,
  // shared initiator port
  output logic [AddrWidth-1:0]   out_awaddr,
  output logic [2:0]             out_awprot,
  output logic [AWUserWidth-1:0] out_awuser,
  output logic                   out_awvalid,
  input  logic                   out_awready,
  output logic [DataWidth-1:0]   out_wdata,
  output logic [DataWidth/8-1:0] out_wstrb,
  output logic [WUserWidth-1:0]  out_wuser,
  output logic                   out_wvalid,
  input  logic                   out_wready,
  input  logic [1:0]             out_bresp,
  input  logic                   out_bvalid,
  output logic                   out_bready,
  output logic [AddrWidth-1:0]   out_araddr,
  output logic [2:0]             out_arprot,
  output logic [ARUserWidth-1:0] out_aruser,
  output logic                   out_arvalid,
  input  logic                   out_arready,
  input  logic [DataWidth-1:0]   out_rdata,
  input  logic [1:0]             out_rresp,
  input  logic [RUserWidth-1:0]  out_ruser,
  input  logic                   out_rvalid,
  output logic                   out_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     w_grant_q, w_grant_d, w_ptr_q, w_ptr_d;
  logic     aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic     r_grant_q, r_grant_d, r_ptr_q, r_ptr_d;

  // Handshake signals of the currently granted requester.
  logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

  assign g_awvalid = w_grant_q ? in1_awvalid : in0_awvalid;
  assign g_wvalid  = w_grant_q ? in1_wvalid  : in0_wvalid;
  assign g_bready  = w_grant_q ? in1_bready  : in0_bready;
  assign g_arvalid = r_grant_q ? in1_arvalid : in0_arvalid;
  assign g_rready  = r_grant_q ? in1_rready  : in0_rready;

  // Payloads follow the grant. They are only meaningful while the matching
  // valid is high.
  assign out_awaddr = w_grant_q ? in1_awaddr : in0_awaddr;
  assign out_awprot = w_grant_q ? in1_awprot : in0_awprot;
  assign out_awuser = w_grant_q ? in1_awuser : in0_awuser;
  assign out_wdata  = w_grant_q ? in1_wdata  : in0_wdata;
  assign out_wstrb  = w_grant_q ? in1_wstrb  : in0_wstrb;
  assign out_wuser  = w_grant_q ? in1_wuser  : in0_wuser;
  assign out_araddr = r_grant_q ? in1_araddr : in0_araddr;
  assign out_arprot = r_grant_q ? in1_arprot : in0_arprot;
  assign out_aruser = r_grant_q ? in1_aruser : in0_aruser;

  // Response payloads go to both requesters. Only the granted requester
  // sees a valid, so the requester that was not granted ignores them.
  assign in0_bresp = out_bresp;
  assign in1_bresp = out_bresp;
  assign in0_rdata = out_rdata;
  assign in1_rdata = out_rdata;
  assign in0_rresp = out_rresp;
  assign in1_rresp = out_rresp;
  assign in0_ruser = out_ruser;
  assign in1_ruser = out_ruser;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_grant_q <= 1'b0;
      w_ptr_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_grant_q <= 1'b0;
      r_ptr_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_grant_q <= w_grant_d;
      w_ptr_q   <= w_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      r_state_q <= r_state_d;
      r_grant_q <= r_grant_d;
      r_ptr_q   <= r_ptr_d;
    end
  end

  // Write path. AW and W complete independently, and the done flags stop
  // each channel from being issued twice. All outputs are forced low while
  // rst is high, so an abandoned transaction never leaks out.
  always_comb begin
    w_state_d   = w_state_q;
    w_grant_d   = w_grant_q;
    w_ptr_d     = w_ptr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    out_awvalid = 1'b0;
    out_wvalid  = 1'b0;
    out_bready  = 1'b0;
    in0_awready = 1'b0;
    in1_awready = 1'b0;
    in0_wready  = 1'b0;
    in1_wready  = 1'b0;
    in0_bvalid  = 1'b0;
    in1_bvalid  = 1'b0;
    if (!rst) begin
      case (w_state_q)
        W_IDLE: begin
          if (in0_awvalid | in1_awvalid) begin
            // A lone requester wins. On a tie, the pointer decides.
            w_grant_d = (in0_awvalid & in1_awvalid) ? w_ptr_q : in1_awvalid;
            w_state_d = W_ADDR;
          end
        end
        W_ADDR: begin
          out_awvalid = g_awvalid & ~aw_done_q;
          out_wvalid  = g_wvalid & ~w_done_q;
          in0_awready = ~w_grant_q & out_awready & ~aw_done_q;
          in1_awready = w_grant_q & out_awready & ~aw_done_q;
          in0_wready  = ~w_grant_q & out_wready & ~w_done_q;
          in1_wready  = w_grant_q & out_wready & ~w_done_q;
          aw_done_d   = aw_done_q | (out_awvalid & out_awready);
          w_done_d    = w_done_q | (out_wvalid & out_wready);
          if (aw_done_d & w_done_d) begin
            w_state_d = W_RESP;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
        W_RESP: begin
          in0_bvalid = ~w_grant_q & out_bvalid;
          in1_bvalid = w_grant_q & out_bvalid;
          out_bready = g_bready;
          if (out_bvalid & g_bready) begin
            w_state_d = W_IDLE;
            w_ptr_d   = ~w_grant_q;
          end
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  // Read path. This is the same arbitration scheme as the write path, with
  // a single address channel.
  always_comb begin
    r_state_d   = r_state_q;
    r_grant_d   = r_grant_q;
    r_ptr_d     = r_ptr_q;
    out_arvalid = 1'b0;
    out_rready  = 1'b0;
    in0_arready = 1'b0;
    in1_arready = 1'b0;
    in0_rvalid  = 1'b0;
    in1_rvalid  = 1'b0;
    if (!rst) begin
      case (r_state_q)
        R_IDLE: begin
          if (in0_arvalid | in1_arvalid) begin
            r_grant_d = (in0_arvalid & in1_arvalid) ? r_ptr_q : in1_arvalid;
            r_state_d = R_ADDR;
          end
        end
        R_ADDR: begin
          out_arvalid = g_arvalid;
          in0_arready = ~r_grant_q & out_arready;
          in1_arready = r_grant_q & out_arready;
          if (g_arvalid & out_arready) begin
            r_state_d = R_DATA;
          end
        end
        R_DATA: begin
          in0_rvalid = ~r_grant_q & out_rvalid;
          in1_rvalid = r_grant_q & out_rvalid;
          out_rready = g_rready;
          if (out_rvalid & g_rready) begin
            r_state_d = R_IDLE;
            r_ptr_d   = ~r_grant_q;
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_br_amba_axil_arbiter_2to1.sv
// tb_br_amba_axil_arbiter_2to1
// Self-checking bench for the 2:1 AXI4-Lite arbiter. The bench drives both
// requesters and the shared subordinate port. A transaction-level model
// tracks which requester owns the write and read paths, and which channels
// of that transaction have completed.
module tb_br_amba_axil_arbiter_2to1;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Requester-side stimulus. The index is the requester number.
  logic [AW-1:0] awaddr_i [2];
  logic [2:0]    awprot_i [2];
  logic [0:0]    awuser_i [2];
  logic [DW-1:0] wdata_i  [2];
  logic [SW-1:0] wstrb_i  [2];
  logic [0:0]    wuser_i  [2];
  logic [AW-1:0] araddr_i [2];
  logic [2:0]    arprot_i [2];
  logic [0:0]    aruser_i [2];
  logic [1:0]    awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;

  logic in0_awready, in1_awready, in0_wready, in1_wready, in0_bvalid, in1_bvalid;
  logic in0_arready, in1_arready, in0_rvalid, in1_rvalid;
  logic [1:0]    in0_bresp, in1_bresp, in0_rresp, in1_rresp;
  logic [DW-1:0] in0_rdata, in1_rdata;
  logic [0:0]    in0_ruser, in1_ruser;

  logic [AW-1:0] out_awaddr;
  logic [2:0]    out_awprot;
  logic [0:0]    out_awuser;
  logic          out_awvalid, out_awready;
  logic [DW-1:0] out_wdata;
  logic [SW-1:0] out_wstrb;
  logic [0:0]    out_wuser;
  logic          out_wvalid, out_wready;
  logic [1:0]    out_bresp;
  logic          out_bvalid, out_bready;
  logic [AW-1:0] out_araddr;
  logic [2:0]    out_arprot;
  logic [0:0]    out_aruser;
  logic          out_arvalid, out_arready;
  logic [DW-1:0] out_rdata;
  logic [1:0]    out_rresp;
  logic [0:0]    out_ruser;
  logic          out_rvalid, out_rready;

  logic [1:0] awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  assign awready_o = {in1_awready, in0_awready};
  assign wready_o  = {in1_wready, in0_wready};
  assign bvalid_o  = {in1_bvalid, in0_bvalid};
  assign arready_o = {in1_arready, in0_arready};
  assign rvalid_o  = {in1_rvalid, in0_rvalid};

  br_amba_axil_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .in0_awaddr(awaddr_i[0]), .in0_awprot(awprot_i[0]), .in0_awuser(awuser_i[0]),
    .in0_awvalid(awvalid_i[0]), .in0_awready(in0_awready),
    .in0_wdata(wdata_i[0]), .in0_wstrb(wstrb_i[0]), .in0_wuser(wuser_i[0]),
    .in0_wvalid(wvalid_i[0]), .in0_wready(in0_wready),
    .in0_bresp(in0_bresp), .in0_bvalid(in0_bvalid), .in0_bready(bready_i[0]),
    .in0_araddr(araddr_i[0]), .in0_arprot(arprot_i[0]), .in0_aruser(aruser_i[0]),
    .in0_arvalid(arvalid_i[0]), .in0_arready(in0_arready),
    .in0_rdata(in0_rdata), .in0_rresp(in0_rresp), .in0_ruser(in0_ruser),
    .in0_rvalid(in0_rvalid), .in0_rready(rready_i[0]),
    .in1_awaddr(awaddr_i[1]), .in1_awprot(awprot_i[1]), .in1_awuser(awuser_i[1]),
    .in1_awvalid(awvalid_i[1]), .in1_awready(in1_awready),
    .in1_wdata(wdata_i[1]), .in1_wstrb(wstrb_i[1]), .in1_wuser(wuser_i[1]),
    .in1_wvalid(wvalid_i[1]), .in1_wready(in1_wready),
    .in1_bresp(in1_bresp), .in1_bvalid(in1_bvalid), .in1_bready(bready_i[1]),
    .in1_araddr(araddr_i[1]), .in1_arprot(arprot_i[1]), .in1_aruser(aruser_i[1]),
    .in1_arvalid(arvalid_i[1]), .in1_arready(in1_arready),
    .in1_rdata(in1_rdata), .in1_rresp(in1_rresp), .in1_ruser(in1_ruser),
    .in1_rvalid(in1_rvalid), .in1_rready(rready_i[1]),
    .out_awaddr(out_awaddr), .out_awprot(out_awprot), .out_awuser(out_awuser),
    .out_awvalid(out_awvalid), .out_awready(out_awready),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wuser(out_wuser),
    .out_wvalid(out_wvalid), .out_wready(out_wready),
    .out_bresp(out_bresp), .out_bvalid(out_bvalid), .out_bready(out_bready),
    .out_araddr(out_araddr), .out_arprot(out_arprot), .out_aruser(out_aruser),
    .out_arvalid(out_arvalid), .out_arready(out_arready),
    .out_rdata(out_rdata), .out_rresp(out_rresp), .out_ruser(out_ruser),
    .out_rvalid(out_rvalid), .out_rready(out_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. A transaction is "active" from the cycle after
  // it is granted until its response handshake completes. The *_ok bits
  // record which request channels have already completed.
  logic wt_active, wt_owner, wt_aw_ok, wt_w_ok, wr_ptr;
  logic rt_active, rt_owner, rt_ar_ok, rd_ptr;

  logic       e_awvalid, e_wvalid, e_bready, e_arvalid, e_rready;
  logic [1:0] e_awready, e_wready, e_bvalid, e_arready, e_rvalid;

  // Expected handshake outputs, derived from who owns each path and which
  // of its channels are still outstanding.
  always_comb begin
    e_awvalid = 1'b0;
    e_wvalid  = 1'b0;
    e_bready  = 1'b0;
    e_arvalid = 1'b0;
    e_rready  = 1'b0;
    e_awready = 2'b00;
    e_wready  = 2'b00;
    e_bvalid  = 2'b00;
    e_arready = 2'b00;
    e_rvalid  = 2'b00;
    if (!rst && wt_active) begin
      if (!(wt_aw_ok && wt_w_ok)) begin
        e_awvalid           = awvalid_i[wt_owner] && !wt_aw_ok;
        e_wvalid            = wvalid_i[wt_owner] && !wt_w_ok;
        e_awready[wt_owner] = out_awready && !wt_aw_ok;
        e_wready[wt_owner]  = out_wready && !wt_w_ok;
      end else begin
        e_bvalid[wt_owner] = out_bvalid;
        e_bready           = bready_i[wt_owner];
      end
    end
    if (!rst && rt_active) begin
      if (!rt_ar_ok) begin
        e_arvalid           = arvalid_i[rt_owner];
        e_arready[rt_owner] = out_arready;
      end else begin
        e_rvalid[rt_owner] = out_rvalid;
        e_rready           = rready_i[rt_owner];
      end
    end
  end

  // Advance the model at each clock edge. A path with no active transaction
  // grants whichever requester is asking, or the round-robin favourite when
  // both are asking. After a response completes, the favourite becomes the
  // other requester.
  always @(posedge clk) begin
    if (rst) begin
      wt_active <= 1'b0; wt_owner <= 1'b0; wt_aw_ok <= 1'b0; wt_w_ok <= 1'b0;
      wr_ptr    <= 1'b0;
      rt_active <= 1'b0; rt_owner <= 1'b0; rt_ar_ok <= 1'b0; rd_ptr  <= 1'b0;
    end else begin
      if (!wt_active) begin
        if (awvalid_i != 2'b00) begin
          wt_active <= 1'b1;
          wt_aw_ok  <= 1'b0;
          wt_w_ok   <= 1'b0;
          wt_owner  <= (awvalid_i == 2'b11) ? wr_ptr : awvalid_i[1];
        end
      end else if (!(wt_aw_ok && wt_w_ok)) begin
        if (e_awvalid && out_awready) wt_aw_ok <= 1'b1;
        if (e_wvalid && out_wready) wt_w_ok <= 1'b1;
      end else if (out_bvalid && e_bready) begin
        wt_active <= 1'b0;
        wr_ptr    <= !wt_owner;
      end
      if (!rt_active) begin
        if (arvalid_i != 2'b00) begin
          rt_active <= 1'b1;
          rt_ar_ok  <= 1'b0;
          rt_owner  <= (arvalid_i == 2'b11) ? rd_ptr : arvalid_i[1];
        end
      end else if (!rt_ar_ok) begin
        if (e_arvalid && out_arready) rt_ar_ok <= 1'b1;
      end else if (out_rvalid && e_rready) begin
        rt_active <= 1'b0;
        rd_ptr    <= !rt_owner;
      end
    end
  end

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput();
    checkVal("wr_ctrl",
      256'({out_awvalid, out_wvalid, awready_o, wready_o, bvalid_o, out_bready}),
      256'({e_awvalid, e_wvalid, e_awready, e_wready, e_bvalid, e_bready}));
    checkVal("rd_ctrl",
      256'({out_arvalid, arready_o, rvalid_o, out_rready}),
      256'({e_arvalid, e_arready, e_rvalid, e_rready}));
    if (e_awvalid)
      checkVal("aw_payload", 256'({out_awaddr, out_awprot, out_awuser}),
        256'({awaddr_i[wt_owner], awprot_i[wt_owner], awuser_i[wt_owner]}));
    if (e_wvalid)
      checkVal("w_payload", 256'({out_wdata, out_wstrb, out_wuser}),
        256'({wdata_i[wt_owner], wstrb_i[wt_owner], wuser_i[wt_owner]}));
    if (e_arvalid)
      checkVal("ar_payload", 256'({out_araddr, out_arprot, out_aruser}),
        256'({araddr_i[rt_owner], arprot_i[rt_owner], aruser_i[rt_owner]}));
    checkVal("broadcast",
      256'({in0_bresp, in1_bresp, in0_rdata, in1_rdata, in0_rresp, in1_rresp, in0_ruser, in1_ruser}),
      256'({out_bresp, out_bresp, out_rdata, out_rdata, out_rresp, out_rresp, out_ruser, out_ruser}));
  endtask

  task automatic settle();
    #1;
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    awvalid_i = '0; wvalid_i = '0; bready_i = '0; arvalid_i = '0; rready_i = '0;
    out_awready = 1'b0; out_wready = 1'b0; out_bvalid = 1'b0; out_bresp = 2'b00;
    out_arready = 1'b0; out_rvalid = 1'b0; out_rdata = '0; out_rresp = 2'b00;
    out_ruser = 1'b0;
    for (int k = 0; k < 2; k++) begin
      awaddr_i[k] = AW'(40'h10_0000_0000 + k * 40'h100);
      awprot_i[k] = 3'(k + 1);
      awuser_i[k] = 1'(k);
      wdata_i[k]  = DW'(64'h1111_0000_0000_0000 * (k + 1));
      wstrb_i[k]  = k ? 8'hF0 : 8'h0F;
      wuser_i[k]  = 1'(k);
      araddr_i[k] = AW'(40'h20_0000_0000 + k * 40'h200);
      arprot_i[k] = 3'(k + 4);
      aruser_i[k] = 1'(1 - k);
    end
  endtask

  // One write-path vector per cycle. exp_w packs
  // {out_awvalid, out_wvalid, awready[1:0], wready[1:0], bvalid[1:0], out_bready}.
  typedef struct {
    logic       rst;
    logic [1:0] awv, wv;
    logic       aw_rdy, w_rdy, bv;
    logic [1:0] brdy;
    logic [8:0] exp_w;
  } wvec_t;

  task automatic applyStimulus(input wvec_t v);
    rst         = v.rst;
    awvalid_i   = v.awv;
    wvalid_i    = v.wv;
    out_awready = v.aw_rdy;
    out_wready  = v.w_rdy;
    out_bvalid  = v.bv;
    bready_i    = v.brdy;
    out_bresp   = 2'($urandom_range(0, 3));
  endtask

  wvec_t vecs [24];

  initial begin
    // Reset with every input asserted, then alternating grants, W ahead of
    // AW, a lone requester, reset during a response, and AW ahead of W.
    vecs[0]  = '{1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 9'b0_0_00_00_00_0};
    vecs[1]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 9'b0_0_00_00_00_0};
    vecs[2]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 9'b1_1_00_01_00_0};
    vecs[3]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 9'b1_0_00_00_00_0};
    vecs[4]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 9'b1_0_00_00_00_0};
    vecs[5]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 9'b1_0_01_00_00_0};
    vecs[6]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 9'b0_0_00_00_00_1};
    vecs[7]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 9'b0_0_00_00_01_1};
    vecs[8]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 9'b0_0_00_00_00_0};
    vecs[9]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 9'b1_1_10_10_00_0};
    vecs[10] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 9'b0_0_00_00_10_0};
    vecs[11] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b10, 9'b0_0_00_00_10_1};
    vecs[12] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 9'b0_0_00_00_00_0};
    vecs[13] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 9'b1_1_10_10_00_0};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11, 9'b0_0_00_00_10_1};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 9'b0_0_00_00_00_0};
    vecs[16] = '{1'b0, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 9'b0_0_00_00_00_0};
    vecs[17] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 9'b0_0_00_00_00_0};
    vecs[18] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 9'b1_1_10_10_00_0};
    vecs[19] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 9'b0_0_00_00_00_0};
    vecs[20] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 9'b0_0_00_00_00_0};
    vecs[21] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 9'b1_1_01_00_00_0};
    vecs[22] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 2'b00, 9'b0_1_00_01_00_0};
    vecs[23] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01, 9'b0_0_00_00_01_1};

    rst = 1'b1;
    clearInputs();
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      settle();
      checkVal($sformatf("vec%0d", i),
        256'({out_awvalid, out_wvalid, awready_o, wready_o, bvalid_o, out_bready}),
        256'(vecs[i].exp_w));
      advance();
    end

    // Concurrent write from in0 and read from in1. Each response must reach
    // only its own requester.
    clearInputs();
    rst = 1'b0;
    awvalid_i = 2'b01; wvalid_i = 2'b01; arvalid_i = 2'b10;
    settle();
    advance();
    out_awready = 1'b1; out_wready = 1'b1; out_arready = 1'b1;
    settle();
    checkVal("concurrent_fwd",
      256'({out_awvalid, out_wvalid, out_arvalid, in0_awready, in1_arready}), 256'(5'b11111));
    advance();
    awvalid_i = 2'b00; wvalid_i = 2'b00; arvalid_i = 2'b00;
    out_awready = 1'b0; out_wready = 1'b0; out_arready = 1'b0;
    out_bvalid = 1'b1; out_bresp = 2'b10; bready_i = 2'b01;
    out_rvalid = 1'b1; out_rdata = 64'hDEAD_BEEF; rready_i = 2'b10;
    settle();
    checkVal("bresp_to_in0", 256'({in0_bvalid, in1_bvalid, in0_bresp}), 256'({1'b1, 1'b0, 2'b10}));
    checkVal("rdata_to_in1", 256'({in1_rvalid, in0_rvalid, in1_rdata}),
      256'({1'b1, 1'b0, 64'hDEAD_BEEF}));
    advance();

    // in1 read with rready held low for 5 cycles while in0 waits to read.
    clearInputs();
    arvalid_i = 2'b10;
    settle();
    advance();
    out_arready = 1'b1;
    settle();
    advance();
    out_arready = 1'b1; out_rvalid = 1'b1; arvalid_i = 2'b01; rready_i = 2'b01;
    for (int k = 0; k < 5; k++) begin
      settle();
      checkVal("rready_held", 256'({out_rready, out_arvalid, in1_rvalid}), 256'(3'b001));
      advance();
    end
    rready_i = 2'b11;
    settle();
    checkVal("r_release", 256'({out_rready, in1_rvalid}), 256'(2'b11));
    advance();
    out_rvalid = 1'b0;
    settle();
    checkVal("r_rearb_idle", 256'(out_arvalid), 256'(1'b0));
    advance();
    settle();
    checkVal("r_next_grant", 256'({out_arvalid, in0_arready, out_araddr}),
      256'({1'b1, 1'b1, araddr_i[0]}));
    advance();

    // Randomised traffic on both paths, with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      awvalid_i   = 2'($urandom_range(0, 3));
      wvalid_i    = 2'($urandom_range(0, 3));
      bready_i    = 2'($urandom_range(0, 3));
      arvalid_i   = 2'($urandom_range(0, 3));
      rready_i    = 2'($urandom_range(0, 3));
      out_awready = 1'($urandom_range(0, 1));
      out_wready  = 1'($urandom_range(0, 1));
      out_bvalid  = 1'($urandom_range(0, 1));
      out_bresp   = 2'($urandom_range(0, 3));
      out_arready = 1'($urandom_range(0, 1));
      out_rvalid  = 1'($urandom_range(0, 1));
      out_rdata   = {$urandom(), $urandom()};
      out_rresp   = 2'($urandom_range(0, 3));
      out_ruser   = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        awaddr_i[k] = AW'({$urandom(), $urandom()});
        awprot_i[k] = 3'($urandom_range(0, 7));
        awuser_i[k] = 1'($urandom_range(0, 1));
        wdata_i[k]  = {$urandom(), $urandom()};
        wstrb_i[k]  = 8'($urandom_range(0, 255));
        wuser_i[k]  = 1'($urandom_range(0, 1));
        araddr_i[k] = AW'({$urandom(), $urandom()});
        arprot_i[k] = 3'($urandom_range(0, 7));
        aruser_i[k] = 1'($urandom_range(0, 1));
      end
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_amba_axil_arbiter_2to1.md
BR_AMBA_AXIL_ARBITER_2TO1 -- requirements
Module: br_amba_axil_arbiter_2to1

Interface
REQ-001 AddrWidth, default 40: address width on all AW/AR channels.
REQ-002 DataWidth, default 64: W/R data width; strobe width is DataWidth/8.
REQ-003 AWUserWidth, WUserWidth, ARUserWidth, RUserWidth, default 1 each: user sideband widths.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in<n>_aw{addr,prot,user,valid}/awready  (n=0,1)  in/out  AddrWidth,3,AWUserWidth,1/1  requester n write address.
REQ-007 in<n>_w{data,strb,user,valid}/wready  in/out  DataWidth,DataWidth/8,WUserWidth,1/1  requester n write data.
REQ-008 in<n>_b{resp,valid}/bready  out/in  2,1/1  requester n write response.
REQ-009 in<n>_ar{addr,prot,user,valid}/arready  in/out  AddrWidth,3,ARUserWidth,1/1  requester n read address.
REQ-010 in<n>_r{data,resp,user,valid}/rready  out/in  DataWidth,2,RUserWidth,1/1  requester n read data.
REQ-011 out_aw*, out_w*, out_b*, out_ar*, out_r*  mirrored directions, same widths  single shared AXI4-Lite initiator port.

Function
REQ-012 Write and read paths SHALL be arbitrated independently, each with one FSM and one round-robin pointer; at most one write and one read outstanding on out_*.
REQ-013 Write FSM states: W_IDLE, W_ADDR, W_RESP; read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-014 W_IDLE: request n = in<n>_awvalid; one requester -> grant it; both -> grant pointer value; none -> stay. Grant registered, W_ADDR entered next cycle (1-cycle arbitration latency).
REQ-015 W_IDLE/W_RESP: out_awvalid=out_wvalid=0, all in<n>_awready/wready=0.
REQ-016 W_ADDR: out_awvalid = in<g>_awvalid & !aw_done; in<g>_awready = out_awready & !aw_done; W channel identical with w_done; non-granted awready/wready=0.
REQ-017 aw_done/w_done SHALL set on their respective out_* handshakes; AW and W may complete in either order or same cycle; W_RESP entered the cycle after both are done (including same-cycle completion); flags clear on W_RESP entry.
REQ-018 W_RESP: in<g>_bvalid = out_bvalid, out_bready = in<g>_bready, other in<n>_bvalid=0; on out_b handshake -> W_IDLE and write pointer = 1-g.
REQ-019 Read FSM SHALL mirror REQ-014..018: R_IDLE arbitrates on in<n>_arvalid; R_ADDR forwards AR of granted requester; AR handshake -> R_DATA; R handshake -> R_IDLE, read pointer = 1-g.
REQ-020 out_aw/w/ar payloads SHALL be muxed from the granted requester; bresp, rdata, rresp, ruser SHALL be broadcast to both requesters (qualified only by valid).
REQ-021 No valid SHALL depend combinationally on its own ready; ready outputs may depend combinationally on out_* ready.
REQ-022 A requester that drops awvalid/arvalid before grant loses its request; no payload is latched by this block.

Reset
REQ-023 During rst: both FSMs IDLE, both pointers 0, aw_done=w_done=0, all valid and ready outputs 0.
REQ-024 rst asserted mid-transaction SHALL abandon it and return to IDLE next cycle; no response forwarded afterwards.

Verification
REQ-025 Both in<n>_awvalid=1 from first post-reset cycle -> grant 0 first, then 1, then 0 (alternating); each write completes with its own bresp.
REQ-026 Only in1 requests writes repeatedly -> in1 granted every time; W_IDLE->W_ADDR latency exactly 1 cycle.
REQ-027 in0 W handshake 3 cycles before AW handshake -> exactly one out_w beat, W_RESP entered cycle after AW handshake.
REQ-028 Concurrent in0 write and in1 read -> both forwarded simultaneously; bresp=2'b10 only to in0, rdata=64'hDEAD_BEEF only to in1.
REQ-029 rst pulsed while in W_RESP with out_bvalid low -> all outputs 0, pointer 0, next request arbitrated normally.
REQ-030 in1_rready held low 5 cycles with out_rvalid=1 -> out_rready low 5 cycles, no new AR issued until R handshake.
